uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single AXI4-Stream input of the UART transmitter among NUM_CH byte-stream requesters. Grants are packet-granular: a granted channel holds the UART until tlast or until MAX_BURST bytes have gone out. When HEADER_EN=1 the arbiter inserts a channel-ID byte ahead of each granted burst, so the far end can demultiplex. The block sits between the requester streams and the UART transmit AXI input (s_axis_*).

Parameters:
NUM_CH, 4, number of requester channels (2..16)
DATA_WIDTH, 8, byte width; must match the UART DATA_WIDTH
HEADER_EN, 1, 1 = emit a header byte before each burst; 0 = no header
HEADER_BASE, 8'hF0, header value = HEADER_BASE + channel index (modulo 2^DATA_WIDTH)
MAX_BURST, 64, maximum data beats per grant (1..65535)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_axis_tdata  in  NUM_CH*DATA_WIDTH  requester data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  NUM_CH  per-channel valid
s_axis_tlast  in  NUM_CH  per-channel end of packet
s_axis_tready  out  NUM_CH  per-channel ready
m_axis_tdata  out  DATA_WIDTH  to the UART transmit input
m_axis_tvalid  out  1  to the UART transmit input
m_axis_tready  in  1  from the UART transmit input
grant  out  $clog2(NUM_CH)  index of the current owner
grant_valid  out  1  a grant is active (HEADER or DATA state)
burst_cut  out  1  one-cycle pulse when a grant ends on MAX_BURST without tlast

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. All state is cleared on assertion, including a reset that arrives mid-burst. Any beat not yet accepted is dropped.
- Reset values:
  - state = IDLE
  - m_axis_tvalid = 0, m_axis_tdata = 0
  - s_axis_tready = 0
  - grant = 0, grant_valid = 0, burst_cut = 0
  - round-robin pointer last = NUM_CH-1, so channel 0 has highest priority first.
- IDLE state:
  - m_axis_tvalid = 0 and s_axis_tready = 0.
  - If any s_axis_tvalid bit is set, select the first requesting channel searching last+1, last+2, … with wrap at NUM_CH.
  - At the next clock edge: grant <= selected, last <= selected, beat counter <= 0.
  - Next state is HEADER if HEADER_EN=1, otherwise DATA.
  - Grant latency is 1 cycle from a valid seen in IDLE.
- HEADER state:
  - m_axis_tvalid = 1, m_axis_tdata = HEADER_BASE + grant, all s_axis_tready = 0.
  - On m_axis_tready=1, go to DATA.
  - The header does not count toward MAX_BURST.
- DATA state (combinational pass-through, no added latency):
  - m_axis_tdata = channel[grant] data, m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; all other ready bits are 0.
  - On each handshake (tvalid[grant] & m_axis_tready) the beat counter increments.
  - If tlast[grant] on the handshake: return to IDLE.
  - Else if the counter reaches MAX_BURST on the handshake: return to IDLE and pulse burst_cut for 1 cycle.
  - If the granted channel drops tvalid mid-packet, the grant is held; no timeout.
- Back-to-back arbitration: every grant passes through IDLE for one cycle. A channel with a packet cut by MAX_BURST re-arbitrates and gets a fresh header when next granted.
- Bubble: with HEADER_EN=0, maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles when the UART is always ready.
- grant_valid = (state != IDLE).
- AXI rules on m_axis:
  - Once m_axis_tvalid is asserted in HEADER it holds until accepted, with stable data.
  - In DATA, stability follows the granted requester, which must itself obey AXI rules.
- Simultaneous requests are resolved only by the round-robin order. No starvation: each requesting channel is served within NUM_CH grants.
- Width rule: beat counter is $clog2(MAX_BURST+1) bits. Header addition truncates to DATA_WIDTH.

Test Plan:
- Reset then ch0 sends 3 bytes {11,22,33} with tlast on 33, HEADER_EN=1, UART always ready -> m_axis sequence F0,11,22,33; grant=0; back to IDLE one cycle after the 33 handshake.
- All 4 channels hold valid with 1-byte packets -> grant order 0,1,2,3,0; headers F0,F1,F2,F3,F0.
- MAX_BURST=4, ch2 streams 10 bytes with tlast on the 10th, no other requesters -> bursts of 4,4,2 bytes; burst_cut pulses twice; each burst preceded by F2.
- m_axis_tready held low for 20 cycles during HEADER -> m_axis_tvalid stays 1 and tdata stays F1; no s_axis_tready asserted.
- ch1 granted and drops tvalid for 5 cycles mid-packet while ch3 is requesting -> grant stays 1; ch3 s_axis_tready stays 0 until ch1 tlast.
- rst asserted asynchronously mid-DATA -> outputs go to reset values immediately without a clock; after release the next grant goes to channel 0 if it is requesting.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmit stream among
// NUM_CH byte requesters, with an optional channel-ID header before each burst.
module uart_tx_arbiter #(
    parameter int                    NUM_CH      = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    HEADER_EN   = 1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE = 8'hF0,
    parameter int                    MAX_BURST   = 64,
    localparam int                   GW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [GW-1:0]                grant,
    output logic                         grant_valid,
    output logic                         burst_cut
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cut_q, cut_d;

    logic            found;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   cand;
    logic            beat;

    // Search last+1, last+2, ... with wrap; the first requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = GW'((int'(last_q) + i) % NUM_CH);
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign beat = s_axis_tvalid[grant_q] & m_axis_tready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cut_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    last_d  = sel;
                    cnt_d   = '0;
                    state_d = (HEADER_EN != 0) ? HEADER : DATA;
                end
            end
            HEADER: begin
                if (m_axis_tready) state_d = DATA;
            end
            DATA: begin
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                    if (s_axis_tlast[grant_q]) begin
                        state_d = IDLE;
                    end else if (cnt_d == CW'(MAX_BURST)) begin
                        state_d = IDLE;
                        cut_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
            cnt_q   <= '0;
            cut_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cut_q   <= cut_d;
        end
    end

    // DATA is a straight pass-through from the owner so no latency is added.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        case (state_q)
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = HEADER_BASE + DATA_WIDTH'(grant_q);
            end
            DATA: begin
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                s_axis_tready[grant_q] = m_axis_tready;
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q != IDLE);
    assign burst_cut   = cut_q;

endmodule
